sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock FIFO with valid/ready handshakes on both sides and an arbitrary (not only power-of-2) depth. It exposes a registered occupancy count, runtime-programmable almost-full/almost-empty flags, and a synchronous flush. It is the same-clock counterpart of the clock-crossing FIFO and is used wherever producer and consumer share one clock. Typical uses are elastic buffering between pipeline stages and credit/watermark-driven flow control.

## Interface
- DATA_WIDTH, 1: payload width in bits.
- TYPE, logic [DATA_WIDTH-1:0]: payload type; storage width is $bits(TYPE).
- DEPTH, 2: number of entries; any integer ≥ 1.
- Derived: ADDR_WIDTH = max(1, $clog2(DEPTH)); LEVEL_WIDTH = $clog2(DEPTH+1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents.
- w_valid  input  1  producer has data.
- w_ready  output  1  FIFO can accept data.
- w_data  input  TYPE  write payload.
- r_valid  output  1  FIFO has data.
- r_ready  input  1  consumer accepts data.
- r_data  output  TYPE  head-of-queue payload (first-word fall-through).
- af_thresh  input  LEVEL_WIDTH  almost-full threshold.
- ae_thresh  input  LEVEL_WIDTH  almost-empty threshold.
- level  output  LEVEL_WIDTH  current occupancy, 0..DEPTH.
- almost_full  output  1  level ≥ af_thresh.
- almost_empty  output  1  level ≤ ae_thresh.

## Operation
- Storage is a register array of DEPTH entries. It is not reset.
- Read pointer rd_ptr and write pointer wr_ptr are ADDR_WIDTH wide. Each increments by 1 and wraps from DEPTH-1 to 0 by explicit compare, not modulo 2^ADDR_WIDTH.
- Full and empty are derived from a registered count, `level`:
  - w_ready = (level != DEPTH).
  - r_valid = (level != 0).
- Handshakes:
  - A write fires when w_valid && w_ready; a read fires when r_valid && r_ready.
  - A write stores w_data at mem[wr_ptr].
  - r_data = mem[rd_ptr], combinational from the registered pointer. It is don't-care while r_valid = 0.
- Level update per edge:
  - write only: +1.
  - read only: −1.
  - both or neither: unchanged.
- Boundary conditions:
  - Simultaneous read and write when level = 0 is impossible, since r_valid = 0. There is no bypass; the data appears one cycle later.
  - When level = DEPTH, w_ready = 0 even if a read fires that cycle. There is no pass-through write.
  - With both firing at 0 < level < DEPTH, both pointers advance and level holds.
- Flush:
  - On an edge with flush = 1, rd_ptr, wr_ptr and level clear to 0.
  - Any write or read handshake in that cycle is discarded; a write is not stored.
  - Flush has priority over all handshakes.
- Flags are combinational from the registered level and the threshold inputs:
  - almost_full = (level ≥ af_thresh).
  - almost_empty = (level ≤ ae_thresh).
  - Threshold values above DEPTH are legal: almost_full never asserts, almost_empty always asserts.
- Static checks:
  - DEPTH ≥ 1 is checked at elaboration; violation is $fatal.
  - Assertions: level ≤ DEPTH at all times; no write fires while level = DEPTH; no read fires while level = 0.

## Timing
- Reset asserted, asynchronous: rd_ptr = wr_ptr = 0 and level = 0. Outputs:
  - r_valid = 0, w_ready = 1.
  - almost_empty = 1.
  - almost_full = (af_thresh == 0).
- The first edge after rst deasserts is a normal operating edge.
- Reset mid-operation empties the FIFO immediately. No stored entry is readable afterwards.
- Write-to-read latency is 1 cycle. A write on edge k gives r_valid = 1 and r_data = that word after edge k.
- Read-to-free latency is 1 cycle. A read on edge k raises w_ready after edge k if the FIFO was full.
- level, r_valid, w_ready and the flags all change only after a clock edge or a threshold-input change. There are no combinational paths from w_valid or r_ready to any output.
- Full throughput: one write and one read per cycle sustained when 0 < level < DEPTH.

## Test plan
- Reset and fill, DEPTH=5, DATA_WIDTH=8, af_thresh=4, ae_thresh=1:
  - Write 0x10..0x14 on consecutive cycles with r_ready = 0.
  - level steps 1..5; almost_empty drops when level = 2; almost_full rises when level = 4; w_ready = 0 after the 5th write.
  - A 6th write with w_valid held is not accepted.
- Drain and wrap-around:
  - From full, read 3 words (0x10, 0x11, 0x12); write 0x15..0x17, which wraps wr_ptr past index 4.
  - Reading out everything yields 0x13..0x17 in order; r_valid = 0 afterwards.
- Simultaneous read and write, level = 2:
  - w_valid = r_valid = r_ready = 1 for 10 cycles with an incrementing payload.
  - level stays 2; output order matches input order; no bubbles.
- Full boundary:
  - At level = 5, hold w_valid = 1 and pulse r_ready for one cycle.
  - That cycle w_ready = 0 and nothing is written; the next cycle w_ready = 1, the write is accepted, and level returns to 5.
- Flush:
  - At level = 3, assert flush together with w_valid = 1 and r_ready = 1.
  - Next cycle: level = 0, r_valid = 0, w_ready = 1; the written word is never read out.
- Async reset mid-stream and DEPTH=1 build:
  - Assert rst between edges: outputs go to reset values immediately, without waiting for an edge.
  - With DEPTH=1, alternating write/read gives level toggling 0/1 and correct data.

Source files
------------

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
//
// Signals
//   w_valid / w_ready / w_data : write side; a beat moves when w_valid && w_ready.
//   r_valid / r_ready / r_data : read side; a beat moves when r_valid && r_ready.
//
// Modports
//   master : the environment (drives w_valid, w_data, r_ready).
//   slave  : the FIFO (drives w_ready, r_valid, r_data).
//
// WIDTH must equal $bits of the payload type used by the FIFO instance.
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 8
);

  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;

  modport master (
    output w_valid,
    output w_data,
    output r_ready,
    input  w_ready,
    input  r_valid,
    input  r_data
  );

  modport slave (
    input  w_valid,
    input  w_data,
    input  r_ready,
    output w_ready,
    output r_valid,
    output r_data
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO of arbitrary depth.
//
// Ports
//   clk          : clock, all state on posedge.
//   rst          : asynchronous active-high reset; empties the FIFO.
//   flush        : synchronous clear; discards any handshake in the same cycle.
//   bus          : sync_fifo_if.slave write/read handshakes and payloads.
//   af_thresh    : almost-full threshold, almost_full = (level >= af_thresh).
//   ae_thresh    : almost-empty threshold, almost_empty = (level <= ae_thresh).
//   level        : registered occupancy, 0..DEPTH.
//   almost_full  : watermark flag.
//   almost_empty : watermark flag.
//
// Full/empty come from the registered level rather than pointer comparison, so
// DEPTH need not be a power of two and pointers wrap by explicit compare.
// No output depends combinationally on w_valid or r_ready.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter type         TYPE        = logic [DATA_WIDTH-1:0],
  parameter int          DEPTH       = 2,
  localparam int         ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int         LEVEL_WIDTH = (DEPTH >= 1) ? $clog2(DEPTH + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  sync_fifo_if.slave             bus,
  input  logic [LEVEL_WIDTH-1:0] af_thresh,
  input  logic [LEVEL_WIDTH-1:0] ae_thresh,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter check
  // ---------------------------------------------------------------------------
  if (DEPTH < 1) begin : g_depth_check
    $fatal(1, "sync_fifo: DEPTH must be >= 1");
  end

  localparam logic [LEVEL_WIDTH-1:0] LevelFull = LEVEL_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  PtrLast   = ADDR_WIDTH'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  TYPE                    mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;

  logic w_ready_int;
  logic r_valid_int;
  logic w_fire;
  logic r_fire;

  // ---------------------------------------------------------------------------
  // Handshake decode (from registered level only)
  // ---------------------------------------------------------------------------
  assign w_ready_int = (level_q != LevelFull);
  assign r_valid_int = (level_q != '0);

  assign w_fire = bus.w_valid & w_ready_int;
  assign r_fire = r_valid_int & bus.r_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;

    if (flush) begin
      // Flush wins over any handshake in the same cycle.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_fire) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (r_fire) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({w_fire, r_fire})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: not reset; a write during flush is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_fire && !flush) begin
      mem[wr_ptr_q] <= TYPE'(bus.w_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.w_ready  = w_ready_int;
  assign bus.r_valid  = r_valid_int;
  assign bus.r_data   = mem[rd_ptr_q];

  assign level        = level_q;
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // Distance from rd_ptr to wr_ptr, modulo DEPTH, must agree with level.
  int ptr_dist;
  int level_mod;
  always_comb begin
    ptr_dist  = (int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH;
    level_mod = int'(level_q) % DEPTH;
  end

  a_level_in_range : assert property (@(posedge clk) disable iff (rst)
    level_q <= LevelFull)
    else $error("sync_fifo: level exceeds DEPTH");

  a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
    (level_q == LevelFull) |-> !w_fire)
    else $error("sync_fifo: write accepted while full");

  a_no_read_when_empty : assert property (@(posedge clk) disable iff (rst)
    (level_q == '0) |-> !r_fire)
    else $error("sync_fifo: read accepted while empty");

  a_rd_ptr_in_range : assert property (@(posedge clk) disable iff (rst)
    rd_ptr_q <= PtrLast)
    else $error("sync_fifo: rd_ptr out of range");

  a_wr_ptr_in_range : assert property (@(posedge clk) disable iff (rst)
    wr_ptr_q <= PtrLast)
    else $error("sync_fifo: wr_ptr out of range");

  a_ptr_level_consistent : assert property (@(posedge clk) disable iff (rst)
    ptr_dist == level_mod)
    else $error("sync_fifo: pointers disagree with level");
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed, table-driven bench for sync_fifo.
// Instance dut5: DEPTH=5, DATA_WIDTH=8, af_thresh=4, ae_thresh=1 (main table).
// Instance dut1: DEPTH=1 build, alternating write/read.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// i.e. the values seen by the next rising edge.
module tb_sync_fifo;

  logic clk;
  logic rst;
  logic flush5;
  logic flush1;
  logic [2:0] af5, ae5, level5;
  logic       af_flag5, ae_flag5;
  logic [0:0] af1, ae1, level1;
  logic       af_flag1, ae_flag1;

  int checks = 0;
  int errors = 0;

  sync_fifo_if #(.WIDTH(8)) bus5 ();
  sync_fifo_if #(.WIDTH(8)) bus1 ();

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush5),
    .bus          (bus5),
    .af_thresh    (af5),
    .ae_thresh    (ae5),
    .level        (level5),
    .almost_full  (af_flag5),
    .almost_empty (ae_flag5)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush1),
    .bus          (bus1),
    .af_thresh    (af1),
    .ae_thresh    (ae1),
    .level        (level1),
    .almost_full  (af_flag1),
    .almost_empty (ae_flag1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       fl;
    int         exp_level;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic wv, logic [7:0] wd, logic rr, logic fl, int lvl,
                              logic [7:0] rd);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.fl = fl; v.exp_level = lvl; v.exp_data = rd;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags/handshakes follow from the expected level and thresholds.
  task automatic check_state(string tag, int depth, int af_t, int ae_t, int lvl_a, logic rv_a,
                             logic wr_a, logic af_a, logic ae_a, logic [7:0] d_a,
                             int exp_lvl, logic [7:0] exp_d);
    check({tag, " level"}, lvl_a, exp_lvl);
    check({tag, " r_valid"}, int'(rv_a), int'(exp_lvl != 0));
    check({tag, " w_ready"}, int'(wr_a), int'(exp_lvl != depth));
    check({tag, " almost_full"}, int'(af_a), int'(exp_lvl >= af_t));
    check({tag, " almost_empty"}, int'(ae_a), int'(exp_lvl <= ae_t));
    if (exp_lvl != 0) check({tag, " r_data"}, int'(d_a), int'(exp_d));
  endtask

  task automatic check5(string tag, int exp_lvl, logic [7:0] exp_d);
    check_state(tag, 5, int'(af5), int'(ae5), int'(level5), bus5.r_valid, bus5.w_ready,
                af_flag5, ae_flag5, bus5.r_data, exp_lvl, exp_d);
  endtask

  task automatic check1(string tag, int exp_lvl, logic [7:0] exp_d);
    check_state(tag, 1, int'(af1), int'(ae1), int'(level1), bus1.r_valid, bus1.w_ready,
                af_flag1, ae_flag1, bus1.r_data, exp_lvl, exp_d);
  endtask

  task automatic step5(logic wv, logic [7:0] wd, logic rr, logic fl);
    @(negedge clk);
    bus5.w_valid = wv; bus5.w_data = wd; bus5.r_ready = rr; flush5 = fl;
    #1;
  endtask

  task automatic step1(logic wv, logic [7:0] wd, logic rr);
    @(negedge clk);
    bus1.w_valid = wv; bus1.w_data = wd; bus1.r_ready = rr;
    #1;
  endtask

  initial begin
    // Vector table: inputs for the cycle, expected outputs seen before its edge.
    add(1, 8'h10, 0, 0, 0, 8'h00);
    add(1, 8'h11, 0, 0, 1, 8'h10);
    add(1, 8'h12, 0, 0, 2, 8'h10);
    add(1, 8'h13, 0, 0, 3, 8'h10);
    add(1, 8'h14, 0, 0, 4, 8'h10);
    add(1, 8'h99, 0, 0, 5, 8'h10);   // 6th write held, refused
    add(1, 8'h99, 0, 0, 5, 8'h10);
    add(0, 8'h00, 1, 0, 5, 8'h10);
    add(0, 8'h00, 1, 0, 4, 8'h11);
    add(0, 8'h00, 1, 0, 3, 8'h12);
    add(1, 8'h15, 0, 0, 2, 8'h13);
    add(1, 8'h16, 0, 0, 3, 8'h13);
    add(1, 8'h17, 0, 0, 4, 8'h13);
    add(0, 8'h00, 1, 0, 5, 8'h13);
    add(0, 8'h00, 1, 0, 4, 8'h14);
    add(0, 8'h00, 1, 0, 3, 8'h15);   // rd_ptr wrapped 4 -> 0
    add(0, 8'h00, 1, 0, 2, 8'h16);
    add(0, 8'h00, 1, 0, 1, 8'h17);
    add(0, 8'h00, 0, 0, 0, 8'h00);
    add(1, 8'h20, 0, 0, 0, 8'h00);
    add(1, 8'h21, 0, 0, 1, 8'h20);
    for (int i = 0; i < 10; i++) add(1, 8'(8'h22 + i), 1, 0, 2, 8'(8'h20 + i));
    add(1, 8'h2C, 0, 0, 2, 8'h2A);
    add(1, 8'h2D, 0, 0, 3, 8'h2A);
    add(1, 8'h2E, 0, 0, 4, 8'h2A);
    add(1, 8'h2F, 1, 0, 5, 8'h2A);   // full: only the read fires
    add(1, 8'h2F, 0, 0, 4, 8'h2B);   // now accepted
    add(0, 8'h00, 1, 0, 5, 8'h2B);
    add(0, 8'h00, 1, 0, 4, 8'h2C);
    add(1, 8'h77, 1, 1, 3, 8'h2D);   // flush with both handshakes
    add(0, 8'h00, 0, 0, 0, 8'h00);
    add(1, 8'h30, 0, 0, 0, 8'h00);
    add(0, 8'h00, 1, 0, 1, 8'h30);   // 0x77 never appears
    add(0, 8'h00, 0, 0, 0, 8'h00);

    rst = 1'b1;
    flush5 = 1'b0; flush1 = 1'b0;
    bus5.w_valid = 1'b0; bus5.w_data = '0; bus5.r_ready = 1'b0;
    bus1.w_valid = 1'b0; bus1.w_data = '0; bus1.r_ready = 1'b0;
    af5 = 3'd0; ae5 = 3'd1; af1 = 1'b1; ae1 = 1'b0;
    #1;
    check("reset af_thresh=0 almost_full", int'(af_flag5), 1);
    af5 = 3'd4;
    #1;
    check5("reset", 0, 8'h00);
    check1("reset d1", 0, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step5(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl);
      check5($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_data);
    end

    // Thresholds: beyond DEPTH and at equality.
    step5(1, 8'h41, 0, 0);
    step5(1, 8'h42, 0, 0);
    step5(1, 8'h43, 0, 0);
    step5(0, 8'h00, 0, 0);
    check5("thr base", 3, 8'h41);
    af5 = 3'd7; ae5 = 3'd6; #1;
    check5("thr above depth", 3, 8'h41);
    af5 = 3'd3; ae5 = 3'd2; #1;
    check5("thr af equal", 3, 8'h41);
    ae5 = 3'd3; #1;
    check5("thr ae equal", 3, 8'h41);
    af5 = 3'd4; ae5 = 3'd1; #1;

    // Asynchronous reset between edges.
    #1;
    rst = 1'b1;
    #1;
    check5("async reset", 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step5(0, 8'h00, 1, 0);
    check5("after reset", 0, 8'h00);
    step5(1, 8'h50, 0, 0);
    check5("post reset wr", 0, 8'h00);
    step5(0, 8'h00, 1, 0);
    check5("post reset rd", 1, 8'h50);
    step5(0, 8'h00, 0, 0);
    check5("post reset empty", 0, 8'h00);

    // DEPTH=1: write, then read while offering a refused write.
    for (int i = 0; i < 4; i++) begin
      step1(1, 8'(8'h60 + i), 0);
      check1($sformatf("d1 wr%0d", i), 0, 8'h00);
      step1(1, 8'hEE, 1);
      check1($sformatf("d1 rd%0d", i), 1, 8'(8'h60 + i));
    end
    step1(0, 8'h00, 0);
    check1("d1 idle", 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
